// File: rtl/inst_sequencer_pkg.sv
// rtl/inst_sequencer_pkg.sv - shared state encoding and error codes for the instruction sequencer
package inst_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_REQ  = 4'd1,
    ST_FETCH_WAIT = 4'd2,
    ST_EXEC       = 4'd3,
    ST_MEM_REQ    = 4'd4,
    ST_MEM_WAIT   = 4'd5,
    ST_WB         = 4'd6,
    ST_HALT       = 4'd7,
    ST_ERROR      = 4'd8
  } seq_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IFU_TO  = 2'd2;
  localparam logic [1:0] ERR_LSU_TO  = 2'd3;

endpackage

// File: rtl/inst_sequencer_timeout.sv
// rtl/inst_sequencer_timeout.sv - response wait timer; expires in the TIMEOUT_CYCLES-th enabled cycle
module seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  // cnt holds the number of fully elapsed wait cycles, so the current cycle is cnt+1
  assign expired = enable && (cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - multi-cycle fetch/exec/mem/writeback control FSM for the NPC core
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ifu_req_valid,
  input  logic                 ifu_req_ready,
  input  logic                 ifu_resp_valid,
  input  logic [31:0]          ifu_resp_inst,
  output logic                 ifu_resp_ready,
  output logic [31:0]          inst_q,
  input  logic                 dec_is_load,
  input  logic                 dec_mem_wen,
  input  logic                 dec_reg_wen,
  input  logic                 dec_is_ebreak,
  input  logic                 dec_inst_not_ipl,
  output logic                 lsu_req_valid,
  output logic                 lsu_req_wen,
  input  logic                 lsu_req_ready,
  input  logic                 lsu_resp_valid,
  output logic                 lsu_resp_ready,
  output logic                 pc_wen,
  output logic                 rf_wen,
  output logic                 commit,
  output logic                 halt,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [CNT_WIDTH-1:0] commit_cnt,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  seq_state_t state, state_d;
  logic       mem_wen_q, reg_wen_q;
  logic [1:0] err_code_q, err_code_d;
  logic       to_waiting, to_expired;

  assign to_waiting = (state == ST_FETCH_WAIT) || (state == ST_MEM_WAIT);

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!to_waiting),
    .enable (to_waiting),
    .expired(to_expired)
  );

  always_comb begin
    state_d        = state;
    err_code_d     = err_code_q;
    ifu_req_valid  = 1'b0;
    ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_req_wen    = 1'b0;
    lsu_resp_ready = 1'b0;
    pc_wen         = 1'b0;
    rf_wen         = 1'b0;
    commit         = 1'b0;
    case (state)
      ST_IDLE: state_d = ST_FETCH_REQ;
      ST_FETCH_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        ifu_resp_ready = 1'b1;
        if (ifu_resp_valid) begin
          state_d = ST_EXEC;
        end else if (to_expired) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_IFU_TO;
        end
      end
      ST_EXEC: begin
        if (dec_inst_not_ipl) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_ILLEGAL;
        end else if (dec_is_ebreak) begin
          commit  = 1'b1;
          state_d = ST_HALT;
        end else if (dec_is_load || dec_mem_wen) begin
          state_d = ST_MEM_REQ;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = mem_wen_q;
        if (lsu_req_ready) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        lsu_resp_ready = 1'b1;
        if (lsu_resp_valid) begin
          state_d = ST_WB;
        end else if (to_expired) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_LSU_TO;
        end
      end
      ST_WB: begin
        pc_wen  = 1'b1;
        rf_wen  = reg_wen_q;
        commit  = 1'b1;
        state_d = ST_FETCH_REQ;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign halt     = (state == ST_HALT);
  assign err      = (state == ST_ERROR);
  assign err_code = err_code_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      inst_q     <= '0;
      mem_wen_q  <= 1'b0;
      reg_wen_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      commit_cnt <= '0;
      cycle_cnt  <= '0;
    end else begin
      state      <= state_d;
      err_code_q <= err_code_d;
      if (state == ST_FETCH_WAIT && ifu_resp_valid) inst_q <= ifu_resp_inst;
      if (state == ST_EXEC) begin
        mem_wen_q <= dec_mem_wen;
        reg_wen_q <= dec_reg_wen;
      end
      if (commit) commit_cnt <= commit_cnt + 1'b1;
      if (state != ST_HALT && state != ST_ERROR) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - scoreboard bench for inst_sequencer with a small behavioural decoder
module tb_inst_sequencer;

  localparam int TO = 8;
  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] LD     = 32'h0000_B103;
  localparam logic [31:0] SD     = 32'h0020_B423;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ILL    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_resp_inst, inst_q;
  logic        dec_is_load, dec_mem_wen, dec_reg_wen, dec_is_ebreak, dec_inst_not_ipl;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
  logic        pc_wen, rf_wen, commit, halt, err;
  logic [1:0]  err_code;
  logic [63:0] commit_cnt, cycle_cnt;

  always #5 clk = ~clk;

  assign dec_is_load      = (inst_q[6:0] == 7'b0000011);
  assign dec_mem_wen      = (inst_q[6:0] == 7'b0100011);
  assign dec_is_ebreak    = (inst_q == EBREAK);
  assign dec_inst_not_ipl = (inst_q == ILL);
  assign dec_reg_wen      = !(dec_mem_wen || dec_is_ebreak || dec_inst_not_ipl);

  inst_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst),
    .ifu_resp_ready(ifu_resp_ready), .inst_q(inst_q),
    .dec_is_load(dec_is_load), .dec_mem_wen(dec_mem_wen), .dec_reg_wen(dec_reg_wen),
    .dec_is_ebreak(dec_is_ebreak), .dec_inst_not_ipl(dec_inst_not_ipl),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .pc_wen(pc_wen), .rf_wen(rf_wen), .commit(commit), .halt(halt), .err(err),
    .err_code(err_code), .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        rf;
    logic        pc;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  longint      tb_cyc = 0;
  logic [63:0] exp_commits;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    exp_commits = '0;
  endtask

  task automatic fetch(input logic [31:0] inst, input int rdy_dly, input int resp_dly,
                       output longint req_cyc);
    int n = 0;
    rec_t r;
    while (!ifu_req_valid && n < 20) begin tick(); n++; end
    chk("ifu_req_valid", ifu_req_valid, 1);
    req_cyc = tb_cyc;
    repeat (rdy_dly) tick();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    chk("fetch_wait_resp_ready", ifu_resp_ready, 1);
    repeat (resp_dly) tick();
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = inst;
    tick();
    ifu_resp_valid = 1'b0;
    ifu_resp_inst  = 32'hDEAD_BEEF;
    chk("inst_q_latched", inst_q, inst);
    if (inst != ILL) begin
      r.inst = inst;
      r.pc   = (inst != EBREAK);
      r.rf   = (inst != EBREAK) && (inst[6:0] != 7'b0100011);
      sb.push_back(r);
    end
  endtask

  task automatic mem(input logic exp_wen, input int rdy_dly, input int resp_dly,
                     input logic [31:0] inst);
    int n = 0;
    while (!lsu_req_valid && n < 10) begin tick(); n++; end
    chk("lsu_req_valid", lsu_req_valid, 1);
    chk("lsu_req_wen", lsu_req_wen, exp_wen);
    repeat (rdy_dly) tick();
    chk("lsu_req_hold", lsu_req_valid, 1);
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    chk("lsu_resp_ready", lsu_resp_ready, 1);
    repeat (resp_dly) begin
      tick();
      chk("inst_q_stable_mem", inst_q, inst);
    end
    lsu_resp_valid = 1'b1;
    tick();
    lsu_resp_valid = 1'b0;
    chk("wb_after_lsu_resp", commit, 1);
  endtask

  task automatic retire(input int bound);
    int n = 0;
    rec_t r;
    while (!commit && n < bound) begin tick(); n++; end
    chk("commit_seen", commit, 1);
    chk("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      r = sb.pop_front();
      chk("retire_inst_q", inst_q, r.inst);
      chk("retire_rf_wen", rf_wen, r.rf);
      chk("retire_pc_wen", pc_wen, r.pc);
    end
    chk("commit_cnt_before", commit_cnt, exp_commits);
    tick();
    exp_commits = exp_commits + 1;
    chk("commit_cnt_after", commit_cnt, exp_commits);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    longint c1, c2;
    logic [63:0] cyc_snap;
    rst_n = 1'b0; ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_inst = '0;
    lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
    exp_commits = '0;
    tick();
    do_reset();
    chk("rst_ifu_req_valid", ifu_req_valid, 0);
    chk("rst_inst_q", inst_q, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_commit_cnt", commit_cnt, 0);
    chk("rst_flags", {halt, err, err_code, commit, pc_wen, rf_wen}, 0);
    tick();
    chk("idle_one_cycle", ifu_req_valid, 1);
    chk("cycle_cnt_run", cycle_cnt, 1);

    // back-to-back addi with zero-wait fetch
    fetch(ADDI, 0, 0, c1);
    chk("exec_no_commit", commit, 0);
    tick();
    retire(0);
    fetch(ADDI, 0, 0, c2);
    chk("alu_latency", c2 - c1, 4);
    tick();
    retire(0);

    // load with stalled LSU handshake, then a zero-wait load for latency
    fetch(LD, 1, 1, c1);
    mem(1'b0, 2, 3, LD);
    retire(0);
    fetch(LD, 0, 0, c1);
    mem(1'b0, 0, 0, LD);
    retire(0);
    fetch(ADDI, 0, 0, c2);
    chk("mem_latency", c2 - c1, 6);
    tick();
    retire(0);

    fetch(SD, 0, 2, c1);
    mem(1'b1, 1, 1, SD);
    retire(0);

    // ebreak retires in EXEC and parks in HALT
    fetch(EBREAK, 1, 2, c1);
    chk("ebreak_commit_exec", commit, 1);
    retire(0);
    chk("halt_set", halt, 1);
    cyc_snap = cycle_cnt;
    repeat (5) tick();
    chk("halt_sticky", halt, 1);
    chk("halt_no_fetch", ifu_req_valid, 0);
    chk("halt_cycle_frozen", cycle_cnt, cyc_snap);
    chk("halt_commit_cnt", commit_cnt, exp_commits);

    do_reset();
    fetch(ILL, 0, 0, c1);
    chk("illegal_no_commit", commit, 0);
    tick();
    chk("illegal_err", {err, err_code}, {1'b1, 2'd1});
    repeat (3) tick();
    chk("illegal_sticky", {err, err_code, ifu_req_valid}, {1'b1, 2'd1, 1'b0});
    chk("illegal_commit_cnt", commit_cnt, 0);

    // fetch response withheld until expiry
    do_reset();
    tick();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    repeat (TO - 1) tick();
    chk("ifu_wait_last_cycle", {err, ifu_resp_ready}, {1'b0, 1'b1});
    tick();
    chk("ifu_timeout", {err, err_code}, {1'b1, 2'd2});

    // response arriving in the expiry cycle wins
    do_reset();
    tick();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    repeat (TO - 1) tick();
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = ADDI;
    tick();
    ifu_resp_valid = 1'b0;
    chk("expiry_resp_wins", {err, inst_q}, {1'b0, ADDI});
    sb.push_back('{inst: ADDI, rf: 1'b1, pc: 1'b1});
    tick();
    retire(0);

    do_reset();
    fetch(LD, 0, 0, c1);
    tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    repeat (TO - 1) tick();
    chk("lsu_wait_last_cycle", {err, lsu_resp_ready}, {1'b0, 1'b1});
    tick();
    chk("lsu_timeout", {err, err_code}, {1'b1, 2'd3});

    // reset lands during MEM_WAIT with a stale response pending
    do_reset();
    fetch(LD, 0, 0, c1);
    tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    tick();
    lsu_resp_valid = 1'b1;
    do_reset();
    chk("rst_mid_resp_ready", lsu_resp_ready, 0);
    chk("rst_mid_counters", {commit_cnt, cycle_cnt}, 128'd0);
    chk("rst_mid_inst_q", inst_q, 0);
    chk("rst_mid_idle", ifu_req_valid, 0);
    tick();
    chk("rst_mid_stale_ignored", {commit, pc_wen, ifu_req_valid}, 3'b001);
    lsu_resp_valid = 1'b0;
    fetch(ADDI, 0, 0, c1);
    tick();
    retire(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
